aes_top: RTL and testbench

- Iterative AES-128 encryption core (FIPS-197), encryption only.
- Computes one round per clock and expands the key on the fly, one round key per round.
- Sits behind a simple start/done handshake.
- Plaintext and key are captured at start; the ciphertext is held until the next operation.

---
 rtl/aes_top.sv | 180 ++++++++++++++++++
 tb/tb_aes_top.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_top.sv
// Iterative AES-128 encryption core (FIPS-197), encryption only.
// Each clock performs one full round and derives that round's key on the fly from the previous one.
// A block takes one load edge plus ten round edges.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - request an encryption; honoured only when idle
//   plaintext  - 128-bit input block, byte 0 in bits [127:120]
//   cipher_key - 128-bit key, byte 0 in bits [127:120]
//   ciphertext - registered result, held until the next accepted start
//   done       - high while ciphertext holds a valid result
module aes_top (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] plaintext,
   input  logic [127:0] cipher_key,
   output logic [127:0] ciphertext,
   output logic         done
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StBusy = 1'b1;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX[a];
   endfunction

   // Multiply by x in GF(2^8), reduction polynomial 0x11b.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      a0 = a[31:24];
      a1 = a[23:16];
      a2 = a[15:8];
      a3 = a[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   logic [0:0]   fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [127:0] rk_q, rk_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] ct_q, ct_d;
   logic         done_q, done_d;

   logic [127:0] sb, sr, mc, rk_next;
   logic [7:0]   rcon;
   logic [31:0]  rot_w, sub_w, temp_w, nw0, nw1, nw2, nw3;

   // Round datapath: SubBytes, ShiftRows, MixColumns on the current state.
   always_comb begin
      sb = '0;
      sr = '0;
      mc = '0;
      for (int i = 0; i < 16; i++) begin
         sb[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
      end
      // Byte 4c+r holds s[r][c]; row r rotates left by r columns.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
      end
   end

   always_comb begin
      unique case (round_q)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   // On-the-fly key expansion: next round key from the current one.
   always_comb begin
      rot_w   = {rk_q[23:0], rk_q[31:24]};
      sub_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
      temp_w  = sub_w ^ {rcon, 24'h000000};
      nw0     = rk_q[127:96] ^ temp_w;
      nw1     = rk_q[95:64] ^ nw0;
      nw2     = rk_q[63:32] ^ nw1;
      nw3     = rk_q[31:0] ^ nw2;
      rk_next = {nw0, nw1, nw2, nw3};
   end

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rk_d    = rk_q;
      round_d = round_q;
      ct_d    = ct_q;
      done_d  = done_q;
      case (fsm_q)
         StIdle: begin
            if (start) begin
               state_d = plaintext ^ cipher_key;
               rk_d    = cipher_key;
               round_d = 4'd1;
               done_d  = 1'b0;
               fsm_d   = StBusy;
            end
         end
         StBusy: begin
            rk_d    = rk_next;
            round_d = round_q + 4'd1;
            if (round_q == 4'd10) begin
               // Final round skips MixColumns.
               state_d = sr ^ rk_next;
               ct_d    = sr ^ rk_next;
               done_d  = 1'b1;
               round_d = 4'd0;
               fsm_d   = StIdle;
            end else begin
               state_d = mc ^ rk_next;
            end
         end
         default: fsm_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= StIdle;
         state_q <= '0;
         rk_q    <= '0;
         round_q <= '0;
         ct_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rk_q    <= rk_d;
         round_q <= round_d;
         ct_q    <= ct_d;
         done_q  <= done_d;
      end
   end

   assign ciphertext = ct_q;
   assign done       = done_q;

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: known FIPS-197 vectors, random blocks against a byte-level
// AES model (S-box derived from GF(2^8) inversion), busy-start rejection, mid-run reset and
// back-to-back operation with start held high.
module tb_aes_top;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [127:0] plaintext;
   logic [127:0] cipher_key;
   logic [127:0] ciphertext;
   logic         done;

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0]   sbox_tab [256];
   logic [127:0] prev_ct;

   aes_top dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .plaintext  (plaintext),
      .cipher_key (cipher_key),
      .ciphertext (ciphertext),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] t;
      t = {v, v};
      return t[15-n -: 8];
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map.
   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h00;
      if (x != 8'h00) begin
         for (int y = 1; y < 256; y++) begin
            if (gmul(x, y[7:0]) == 8'h01) inv = y[7:0];
         end
      end
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0]  w [44];
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [7:0]   rc;
      logic [31:0]  tmp;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]],
                   sbox_tab[tmp[7:0]]};
            tmp[31:24] = tmp[31:24] ^ rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[r][c] = sbox_tab[s[r][(c+r)%4]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
               if (rnd < 10)
                  s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^
                            t[(r+2)%4][c] ^ t[(r+3)%4][c];
               else
                  s[r][c] = t[r][c];
            end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
      end
      res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127-8*(4*c+r) -: 8] = s[r][c];
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a block and pulse start; returns just after the accept edge.
   task automatic start_block(input logic [127:0] pt, input logic [127:0] key);
      plaintext  = pt;
      cipher_key = key;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      check_eq("accept_clears_done", {127'd0, done}, 128'd0);
      check_eq("ct_held_on_accept", ciphertext, prev_ct);
   endtask

   // Edges after the accept edge until done; the accept edge is edge 1 of 11.
   task automatic wait_done(input int already, output int n);
      n = already;
      while (!done && n < 30) begin
         tick();
         n++;
      end
   endtask

   task automatic run_vector(input string tag, input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] exp);
      int n;
      start_block(pt, key);
      wait_done(0, n);
      check_eq({tag, "_latency"}, 128'(n), 128'd10);
      check_eq({tag, "_ct"}, ciphertext, exp);
      prev_ct = exp;
   endtask

   initial begin
      int n;
      int rises;
      logic prev_done;
      logic [127:0] pt1, k1, pt2, k2, e1, e2;

      for (int x = 0; x < 256; x++) sbox_tab[x] = sbox_ref(x[7:0]);

      rst_n      = 1'b0;
      start      = 1'b0;
      plaintext  = '0;
      cipher_key = '0;
      prev_ct    = '0;
      #5;
      check_eq("reset_ct", ciphertext, 128'd0);
      check_eq("reset_done", {127'd0, done}, 128'd0);
      #15 rst_n = 1'b1;
      tick();

      // Known-answer vectors.
      run_vector("kat_c1", 128'h00112233445566778899aabbccddeeff,
                 128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      run_vector("kat_b", 128'h3243f6a8885a308d313198a2e0370734,
                 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32);
      run_vector("kat_zero", 128'd0, 128'd0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

      // Random blocks against the model.
      for (int i = 0; i < 4; i++) begin
         pt1 = {$urandom, $urandom, $urandom, $urandom};
         k1  = {$urandom, $urandom, $urandom, $urandom};
         run_vector("rand", pt1, k1, aes_model(pt1, k1));
         repeat ($urandom_range(0, 3)) tick();
      end

      // start pulsed while busy with different inputs is ignored.
      pt1 = {$urandom, $urandom, $urandom, $urandom};
      k1  = {$urandom, $urandom, $urandom, $urandom};
      e1  = aes_model(pt1, k1);
      start_block(pt1, k1);
      repeat (3) tick();
      plaintext  = {$urandom, $urandom, $urandom, $urandom};
      cipher_key = {$urandom, $urandom, $urandom, $urandom};
      start      = 1'b1;
      tick();
      start      = 1'b0;
      wait_done(4, n);
      check_eq("busy_start_latency", 128'(n), 128'd10);
      check_eq("busy_start_ct", ciphertext, e1);
      prev_ct   = e1;
      rises     = 0;
      prev_done = done;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done && !prev_done) rises++;
         prev_done = done;
      end
      check_eq("busy_start_single_done", 128'(rises), 128'd0);
      check_eq("done_held", {127'd0, done}, 128'd1);
      check_eq("ct_held", ciphertext, e1);

      // Reset during round 5 aborts immediately.
      start_block(pt1 ^ 128'h1, k1);
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      check_eq("midrst_ct", ciphertext, 128'd0);
      check_eq("midrst_done", {127'd0, done}, 128'd0);
      tick();
      rst_n   = 1'b1;
      prev_ct = '0;
      tick();
      run_vector("after_rst", 128'h3243f6a8885a308d313198a2e0370734,
                 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32);

      // Back-to-back with start held high.
      pt1 = {$urandom, $urandom, $urandom, $urandom};
      k1  = {$urandom, $urandom, $urandom, $urandom};
      pt2 = {$urandom, $urandom, $urandom, $urandom};
      k2  = {$urandom, $urandom, $urandom, $urandom};
      e1  = aes_model(pt1, k1);
      e2  = aes_model(pt2, k2);
      plaintext  = pt1;
      cipher_key = k1;
      start      = 1'b1;
      tick();
      wait_done(0, n);
      check_eq("b2b_first_latency", 128'(n), 128'd10);
      check_eq("b2b_first_ct", ciphertext, e1);
      plaintext  = pt2;
      cipher_key = k2;
      tick();
      check_eq("b2b_done_one_cycle", {127'd0, done}, 128'd0);
      check_eq("b2b_ct_stable", ciphertext, e1);
      wait_done(0, n);
      start = 1'b0;
      check_eq("b2b_second_latency", 128'(n), 128'd10);
      check_eq("b2b_second_ct", ciphertext, e2);
      tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
